// File: rtl/sprite_compositor.sv
// sprite_compositor
//   Composites NUM_SPRITES sprite layers over a flat background colour with a
//   fixed two-stage pipeline. Sprite 0 has the highest priority. Pixels equal to
//   KEY_COLOR are transparent. Sprite positions and enables are double-buffered.
//   The shadow copy is loaded on frame_start, so a frame never mixes old and new
//   positions. A per-frame flag reports opaque overlap between sprite 0 and any
//   other sprite.
//
// Ports
//   sys_clk, sys_rst_n  clock (rising edge) and asynchronous active-low reset
//   video_on, x, y      active-video flag and pixel coordinates (stage 0 input)
//   frame_start         1-cycle pulse at start of vblank; loads shadow, ends frame
//   spr_x_in, spr_y_in  pending sprite positions, sprite i at [i*SCREEN_WIDTH +: SCREEN_WIDTH]
//   spr_en_in           pending sprite enables
//   spr_addr            registered sprite ROM addresses, sprite i at [i*ADDR_W +: ADDR_W]
//   spr_rom_data        ROM read data for the address currently on spr_addr
//   rgb                 registered composited pixel, 2 cycles after x/y
//   collision           sprite-0 overlap flag for the previous frame
module sprite_compositor #(
  parameter int PIXEL_WIDTH  = 12,
  parameter int SCREEN_WIDTH = 10,
  parameter int NUM_SPRITES  = 4,
  parameter int SPR_W        = 32,
  parameter int SPR_H        = 32,
  parameter logic [PIXEL_WIDTH-1:0] KEY_COLOR = 12'hF0F,
  parameter logic [PIXEL_WIDTH-1:0] BG_COLOR  = 12'hFFF,
  parameter int ADDR_W       = $clog2(SPR_W*SPR_H)
) (
  input  logic                                 sys_clk,
  input  logic                                 sys_rst_n,
  input  logic                                 video_on,
  input  logic [SCREEN_WIDTH-1:0]              x,
  input  logic [SCREEN_WIDTH-1:0]              y,
  input  logic                                 frame_start,
  input  logic [NUM_SPRITES*SCREEN_WIDTH-1:0]  spr_x_in,
  input  logic [NUM_SPRITES*SCREEN_WIDTH-1:0]  spr_y_in,
  input  logic [NUM_SPRITES-1:0]               spr_en_in,
  output logic [NUM_SPRITES*ADDR_W-1:0]        spr_addr,
  input  logic [NUM_SPRITES*PIXEL_WIDTH-1:0]   spr_rom_data,
  output logic [PIXEL_WIDTH-1:0]               rgb,
  output logic                                 collision
);

  // Sprite extents widened by one bit so that sx+SPR_W cannot wrap to 0
  localparam logic [SCREEN_WIDTH:0] SPR_W_EXT = (SCREEN_WIDTH+1)'(SPR_W);
  localparam logic [SCREEN_WIDTH:0] SPR_H_EXT = (SCREEN_WIDTH+1)'(SPR_H);
  localparam logic [ADDR_W-1:0]     ROW_PITCH = ADDR_W'(SPR_W);

  logic [NUM_SPRITES*SCREEN_WIDTH-1:0] shadow_x;
  logic [NUM_SPRITES*SCREEN_WIDTH-1:0] shadow_y;
  logic [NUM_SPRITES-1:0]              shadow_en;

  logic [NUM_SPRITES-1:0]        hit;
  logic [NUM_SPRITES*ADDR_W-1:0] addr_next;
  logic [SCREEN_WIDTH:0]         px, py, sx, sy, dx, dy;

  logic [NUM_SPRITES-1:0]        hit_d;
  logic                          video_on_d;

  logic [NUM_SPRITES-1:0]        opaque;
  logic [PIXEL_WIDTH-1:0]        pixel_next;
  logic                          coll_term;
  logic                          coll_acc;

  // Shadow position registers: the whole set is captured only on frame_start,
  // so the picture is built from one consistent snapshot per frame.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      shadow_x  <= '0;
      shadow_y  <= '0;
      shadow_en <= '0;
    end else if (frame_start) begin
      shadow_x  <= spr_x_in;
      shadow_y  <= spr_y_in;
      shadow_en <= spr_en_in;
    end
  end

  // Stage 0 hit test and ROM address generation.
  // The address is forced to 0 for sprites that are not hit.
  always_comb begin
    hit       = '0;
    addr_next = '0;
    px        = {1'b0, x};
    py        = {1'b0, y};
    sx        = '0;
    sy        = '0;
    dx        = '0;
    dy        = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      sx = {1'b0, shadow_x[i*SCREEN_WIDTH +: SCREEN_WIDTH]};
      sy = {1'b0, shadow_y[i*SCREEN_WIDTH +: SCREEN_WIDTH]};
      dx = px - sx;
      dy = py - sy;
      hit[i] = shadow_en[i] && (px >= sx) && (px < sx + SPR_W_EXT)
                            && (py >= sy) && (py < sy + SPR_H_EXT);
      if (hit[i]) begin
        addr_next[i*ADDR_W +: ADDR_W] = ADDR_W'(dy) * ROW_PITCH + ADDR_W'(dx);
      end
    end
  end

  // Stage 0 registers: the ROM addresses, plus the hit vector and video_on
  // carried alongside so they line up with the ROM data in stage 1.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      spr_addr   <= '0;
      hit_d      <= '0;
      video_on_d <= 1'b0;
    end else begin
      spr_addr   <= addr_next;
      hit_d      <= hit;
      video_on_d <= video_on;
    end
  end

  // Stage 1 priority mux. Scanning from the highest index down leaves the
  // lowest-index opaque sprite as the winner.
  always_comb begin
    opaque     = '0;
    pixel_next = BG_COLOR;
    for (int i = NUM_SPRITES-1; i >= 0; i--) begin
      opaque[i] = hit_d[i] && (spr_rom_data[i*PIXEL_WIDTH +: PIXEL_WIDTH] != KEY_COLOR);
      if (opaque[i]) begin
        pixel_next = spr_rom_data[i*PIXEL_WIDTH +: PIXEL_WIDTH];
      end
    end
    if (!video_on_d) begin
      pixel_next = '0;
    end
    coll_term = video_on_d && opaque[0] && (|(opaque >> 1));
  end

  // Output pixel register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rgb <= '0;
    end else begin
      rgb <= pixel_next;
    end
  end

  // Collision accumulator. The term from the frame_start cycle itself is
  // included in the reported flag. That term is not carried into the new frame.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      coll_acc  <= 1'b0;
      collision <= 1'b0;
    end else if (frame_start) begin
      collision <= coll_acc | coll_term;
      coll_acc  <= 1'b0;
    end else begin
      coll_acc  <= coll_acc | coll_term;
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor
//   Directed test of sprite_compositor. The stimulus process drives pixels and
//   queues each expected response with the cycle it is due. A separate monitor
//   process pops and compares the due entries on every falling edge.
module tb_sprite_compositor;

  localparam int SW = 10;
  localparam int PW = 12;
  localparam int NS = 4;
  localparam int AW = 10;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic              video_on;
  logic [SW-1:0]     x, y;
  logic              frame_start;
  logic [NS*SW-1:0]  spr_x_in, spr_y_in;
  logic [NS-1:0]     spr_en_in;
  logic [NS*AW-1:0]  spr_addr;
  logic [NS*PW-1:0]  spr_rom_data;
  logic [PW-1:0]     rgb;
  logic              collision;

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int          kind;
    int          idx;
    logic [15:0] exp;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];

  sprite_compositor dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .video_on     (video_on),
    .x            (x),
    .y            (y),
    .frame_start  (frame_start),
    .spr_x_in     (spr_x_in),
    .spr_y_in     (spr_y_in),
    .spr_en_in    (spr_en_in),
    .spr_addr     (spr_addr),
    .spr_rom_data (spr_rom_data),
    .rgb          (rgb),
    .collision    (collision)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // kind 0 = rgb, 1 = spr_addr of sprite idx, 2 = collision
  function automatic logic [15:0] actualOf(int kind, int idx);
    case (kind)
      0:       return 16'(rgb);
      1:       return 16'(spr_addr[idx*AW +: AW]);
      default: return 16'(collision);
    endcase
  endfunction

  task automatic checkOutput(input exp_t e);
    logic [15:0] act;
    act = actualOf(e.kind, e.idx);
    compared++;
    if (act !== e.exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.exp, cyc);
    end
  endtask

  // Monitor: compare everything due this cycle; anything overdue is an error
  initial begin
    forever begin
      @(negedge sys_clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          checkOutput(sb[i]);
          sb.delete(i);
        end else if (sb[i].due < cyc) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL %s: never compared, expected %h", sb[i].name, sb[i].exp);
          sb.delete(i);
        end
      end
    end
  end

  task automatic expectOutput(input int kind, input int idx, input logic [15:0] exp,
                              input int delay, input string name);
    exp_t e;
    e.kind = kind;
    e.idx  = idx;
    e.exp  = exp;
    e.due  = cyc + delay;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic applyStimulus(input int px, input int py, input logic von, input logic fs);
    x           = px[SW-1:0];
    y           = py[SW-1:0];
    video_on    = von;
    frame_start = fs;
  endtask

  task automatic pixel(input int px, input int py, input logic von,
                       input logic [15:0] exp, input bit chk, input string name);
    applyStimulus(px, py, von, 1'b0);
    if (chk) expectOutput(0, 0, exp, 2, name);
    tick();
  endtask

  task automatic addrPixel(input int px, input int py, input int idx, input int addr,
                           input logic [15:0] exp, input string name);
    applyStimulus(px, py, 1'b1, 1'b0);
    expectOutput(1, idx, 16'(addr), 1, {name, "_addr"});
    expectOutput(0, 0, exp, 2, name);
    tick();
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) pixel(500, 500, 1'b1, 16'h0, 1'b0, "");
  endtask

  task automatic frameStart(input logic exp_coll, input string name);
    applyStimulus(500, 500, 1'b1, 1'b1);
    expectOutput(2, 0, 16'(exp_coll), 1, name);
    tick();
    frame_start = 1'b0;
  endtask

  task automatic setSprite(input int i, input int sxv, input int syv);
    spr_x_in[i*SW +: SW] = sxv[SW-1:0];
    spr_y_in[i*SW +: SW] = syv[SW-1:0];
  endtask

  task automatic setRom(input int i, input logic [PW-1:0] c);
    spr_rom_data[i*PW +: PW] = c;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: bench did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sys_rst_n    = 1'b0;
    video_on     = 1'b0;
    x            = '0;
    y            = '0;
    frame_start  = 1'b0;
    spr_x_in     = '0;
    spr_y_in     = '0;
    spr_en_in    = '0;
    spr_rom_data = '0;
    tick();

    // Reset state
    expectOutput(0, 0, 16'h000, 0, "reset_rgb");
    for (int i = 0; i < NS; i++) expectOutput(1, i, 16'h0, 0, $sformatf("reset_addr%0d", i));
    expectOutput(2, 0, 16'h0, 0, "reset_coll");
    tick();
    sys_rst_n = 1'b1;

    // 1: all sprites disabled -> background everywhere
    frameStart(1'b0, "t1_coll");
    pixel(0,   0,   1'b1, 16'hFFF, 1'b1, "t1_bg_a");
    pixel(320, 240, 1'b1, 16'hFFF, 1'b1, "t1_bg_b");
    pixel(639, 479, 1'b1, 16'hFFF, 1'b1, "t1_bg_c");
    pixel(100, 50,  1'b1, 16'hFFF, 1'b1, "t1_bg_d");

    // 2: single sprite, address generation and right/bottom edges
    setSprite(1, 100, 50);
    spr_en_in = 4'b0010;
    setRom(1, 12'h00F);
    frameStart(1'b0, "t2_coll");
    addrPixel(100, 50, 1, 0,   16'h00F, "t2_origin");
    addrPixel(131, 50, 1, 31,  16'h00F, "t2_right");
    addrPixel(132, 50, 1, 0,   16'hFFF, "t2_past_right");
    pixel(99, 50, 1'b1, 16'hFFF, 1'b1, "t2_left_of");
    addrPixel(100, 81, 1, 992, 16'h00F, "t2_bottom");
    pixel(100, 82, 1'b1, 16'hFFF, 1'b1, "t2_below");
    pixel(100, 50, 1'b0, 16'h000, 1'b1, "t2_blank");
    gap(2);

    // 3: key colour on sprite 0 shows sprite 2; opaque sprite 0 wins
    setSprite(0, 10, 10);
    setSprite(2, 10, 10);
    spr_en_in = 4'b0101;
    setRom(0, 12'hF0F);
    setRom(2, 12'h2A6);
    frameStart(1'b0, "t3_coll");
    pixel(15, 12, 1'b1, 16'h2A6, 1'b1, "t3_key_through");
    pixel(10, 10, 1'b1, 16'h2A6, 1'b1, "t3_corner");
    pixel(41, 41, 1'b1, 16'h2A6, 1'b1, "t3_far_corner");
    pixel(42, 10, 1'b1, 16'hFFF, 1'b1, "t3_outside");
    gap(2);
    setRom(0, 12'h800);
    pixel(15, 12, 1'b1, 16'h800, 1'b1, "t3_prio0");
    pixel(42, 10, 1'b1, 16'hFFF, 1'b1, "t3_outside2");
    gap(2);

    // 4: pending position change has no effect until frame_start
    spr_en_in = 4'b0100;
    frameStart(1'b1, "t3_overlap_coll");
    pixel(15, 12, 1'b1, 16'h2A6, 1'b1, "t4_before");
    setSprite(2, 200, 10);
    pixel(15,  12, 1'b1, 16'h2A6, 1'b1, "t4_hold_old");
    pixel(205, 12, 1'b1, 16'hFFF, 1'b1, "t4_hold_new");
    gap(2);
    frameStart(1'b0, "t4_coll");
    pixel(15,  12, 1'b1, 16'hFFF, 1'b1, "t4_old_pos");
    pixel(205, 12, 1'b1, 16'h2A6, 1'b1, "t4_new_pos");
    gap(2);

    // 5: collision between sprites 0 and 3, reported for exactly one frame
    setSprite(0, 300, 300);
    setSprite(3, 310, 300);
    spr_en_in = 4'b1001;
    setRom(3, 12'h0C0);
    frameStart(1'b0, "t5_coll_pre");
    pixel(305, 305, 1'b1, 16'h800, 1'b1, "t5_only0");
    pixel(315, 305, 1'b1, 16'h800, 1'b1, "t5_overlap_prio");
    pixel(335, 305, 1'b1, 16'h0C0, 1'b1, "t5_only3");
    gap(2);
    frameStart(1'b1, "t5_coll_k");
    pixel(305, 305, 1'b1, 16'h800, 1'b1, "t5_k1_only0");
    pixel(335, 305, 1'b1, 16'h0C0, 1'b1, "t5_k1_only3");
    gap(2);
    frameStart(1'b0, "t5_coll_k1");
    pixel(315, 305, 1'b1, 16'h800, 1'b1, "t5_late_overlap");
    frameStart(1'b1, "t5_coll_same_cycle");
    gap(2);
    frameStart(1'b0, "t5_coll_cleared");

    // 6: sprite at the right screen edge must not wrap to x=0..3
    setSprite(1, 1020, 0);
    spr_en_in = 4'b0010;
    setRom(1, 12'h00F);
    frameStart(1'b0, "t6_coll");
    for (int i = 0; i < 4; i++) pixel(i, 0, 1'b1, 16'hFFF, 1'b1, $sformatf("t6_nowrap_x%0d", i));
    pixel(1020, 0, 1'b1, 16'h00F, 1'b1, "t6_edge");
    addrPixel(1023, 5, 1, 163, 16'h00F, "t6_far");

    // Asynchronous reset mid-line, then background until enables reload
    pixel(1021, 0, 1'b1, 16'h00F, 1'b1, "t6_prereset");
    pixel(1021, 0, 1'b1, 16'h0, 1'b0, "");
    pixel(1021, 0, 1'b1, 16'h0, 1'b0, "");
    sys_rst_n = 1'b0;
    expectOutput(0, 0, 16'h000, 0, "t6_async_rgb");
    expectOutput(1, 1, 16'h0,   0, "t6_async_addr");
    expectOutput(2, 0, 16'h0,   0, "t6_async_coll");
    tick();
    tick();
    sys_rst_n = 1'b1;
    pixel(1021, 0, 1'b1, 16'hFFF, 1'b1, "t6_post_reset_bg");
    pixel(1022, 0, 1'b1, 16'hFFF, 1'b1, "t6_post_reset_bg2");
    gap(1);
    frameStart(1'b0, "t6_reload_coll");
    pixel(1021, 0, 1'b1, 16'h00F, 1'b1, "t6_reloaded");
    gap(3);

    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
